// File: rtl/wb_arbiter.sv
// Single write-port arbiter for the register file: merges one-cycle EX results with
// buffered long-latency results, and reports destinations that have not yet been written.
module wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int REG_W        = 6,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ex_valid,
  input  logic [REG_W-1:0]              ex_rd,
  input  logic [DATA_W-1:0]             ex_data,
  output logic                          ex_stall,
  input  logic                          mu_valid,
  output logic                          mu_ready,
  input  logic [REG_W-1:0]              mu_rd,
  input  logic [DATA_W-1:0]             mu_data,
  output logic [REG_W-1:0]              WB_rd,
  output logic [DATA_W-1:0]             WB_data,
  input  logic [REG_W-1:0]              hz_rs1,
  input  logic [REG_W-1:0]              hz_rs2,
  output logic                          hz_rs1_pending,
  output logic                          hz_rs2_pending,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          proto_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT) + 1;
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_ent_t;

  wb_ent_t           fifo_q [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              stall_q, stall_d, perr_q, perr_d;
  logic [REG_W-1:0]  wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              empty, full, mu_hs, ex_ok, pop, push, ex_win, bypass;
  wb_ent_t           head;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign mu_ready = rst_n && !full;
  assign mu_hs    = mu_valid && mu_ready;
  assign ex_ok    = ex_valid && (ex_rd != ZERO_REG);
  assign head     = fifo_q[rd_ptr_q];

  always_comb begin
    wb_rd_d   = ZERO_REG;
    wb_data_d = '0;
    pop       = 1'b0;
    ex_win    = 1'b0;
    bypass    = 1'b0;
    // A pending stall forces the FIFO head through regardless of EX.
    if (!empty && (stall_q || !ex_ok)) begin
      pop       = 1'b1;
      wb_rd_d   = head.rd;
      wb_data_d = head.data;
    end else if (ex_ok) begin
      ex_win    = 1'b1;
      wb_rd_d   = ex_rd;
      wb_data_d = ex_data;
    end else if (mu_hs) begin
      bypass = 1'b1;
      if (mu_rd != ZERO_REG) begin
        wb_rd_d   = mu_rd;
        wb_data_d = mu_data;
      end
    end
    push     = mu_hs && !bypass && (mu_rd != ZERO_REG);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);
    perr_d   = perr_q | (ex_valid & stall_q);
    stall_d  = 1'b0;
    starve_d = '0;
    if (!empty && ex_win) begin
      if (starve_q == SW'(STARVE_LIMIT - 1)) stall_d  = 1'b1;
      else                                   starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      stall_q   <= 1'b0;
      perr_q    <= 1'b0;
      wb_rd_q   <= ZERO_REG;
      wb_data_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      stall_q   <= stall_d;
      perr_q    <= perr_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Storage needs no reset: occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{rd: mu_rd, data: mu_data};
  end

  always_comb begin
    hz_rs1_pending = 1'b0;
    hz_rs2_pending = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        if (fifo_q[rd_ptr_q + PW'(i)].rd == hz_rs1) hz_rs1_pending = 1'b1;
        if (fifo_q[rd_ptr_q + PW'(i)].rd == hz_rs2) hz_rs2_pending = 1'b1;
      end
    end
    if (mu_hs && mu_rd == hz_rs1) hz_rs1_pending = 1'b1;
    if (mu_hs && mu_rd == hz_rs2) hz_rs2_pending = 1'b1;
    if (wb_rd_q == hz_rs1)        hz_rs1_pending = 1'b1;
    if (wb_rd_q == hz_rs2)        hz_rs2_pending = 1'b1;
    if (hz_rs1 == ZERO_REG)       hz_rs1_pending = 1'b0;
    if (hz_rs2 == ZERO_REG)       hz_rs2_pending = 1'b0;
  end

  assign ex_stall   = stall_q;
  assign proto_err  = perr_q;
  assign WB_rd      = wb_rd_q;
  assign WB_data    = wb_data_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and randomized checks of wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int REG_W  = 6;
  localparam int DEPTH  = 4;
  localparam int LIMIT  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              ex_valid = 0, mu_valid = 0;
  logic [REG_W-1:0]  ex_rd = 0, mu_rd = 0, hz_rs1 = 0, hz_rs2 = 0;
  logic [DATA_W-1:0] ex_data = 0, mu_data = 0;
  logic              ex_stall, mu_ready, hz_rs1_pending, hz_rs2_pending, proto_err;
  logic [REG_W-1:0]  WB_rd;
  logic [DATA_W-1:0] WB_data;
  logic [$clog2(DEPTH):0] fifo_count;

  wb_arbiter #(.DATA_W(DATA_W), .REG_W(REG_W), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_stall(ex_stall),
    .mu_valid(mu_valid), .mu_ready(mu_ready), .mu_rd(mu_rd), .mu_data(mu_data),
    .WB_rd(WB_rd), .WB_data(WB_data),
    .hz_rs1(hz_rs1), .hz_rs2(hz_rs2),
    .hz_rs1_pending(hz_rs1_pending), .hz_rs2_pending(hz_rs2_pending),
    .fifo_count(fifo_count), .proto_err(proto_err)
  );

  int tests = 0, fails = 0;

  typedef struct {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              mq[$];
  logic [REG_W-1:0]  m_wb_rd;
  logic [DATA_W-1:0] m_wb_data;
  int                m_starve;
  bit                m_stall, m_perr, last_hs;
  logic [REG_W-1:0]  wb_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit pend(input logic [REG_W-1:0] hz, input bit hs, input logic [REG_W-1:0] mrd);
    if (hz == 0) return 1'b0;
    foreach (mq[i]) if (mq[i].rd == hz) return 1'b1;
    if (hs && mrd == hz) return 1'b1;
    return (m_wb_rd == hz);
  endfunction

  task automatic model_clear();
    mq.delete();
    m_wb_rd = 0; m_wb_data = 0; m_starve = 0; m_stall = 0; m_perr = 0; last_hs = 0;
  endtask

  // One clock: drive, check combinational outputs, clock, advance model, check registered outputs.
  task automatic step(input bit ev, input logic [REG_W-1:0] erd, input logic [DATA_W-1:0] ed,
                      input bit mv, input logic [REG_W-1:0] mrd, input logic [DATA_W-1:0] md,
                      input logic [REG_W-1:0] h1, input logic [REG_W-1:0] h2);
    bit mrdy, hs, nonempty, exwin, bypass;
    ent_t e;
    ex_valid = ev; ex_rd = erd; ex_data = ed;
    mu_valid = mv; mu_rd = mrd; mu_data = md;
    hz_rs1 = h1; hz_rs2 = h2;
    #1;
    mrdy = (mq.size() != DEPTH);
    hs   = mv && mrdy;
    chk("mu_ready", {63'd0, mu_ready}, {63'd0, mrdy});
    chk("hz_rs1_pending", {63'd0, hz_rs1_pending}, {63'd0, pend(h1, hs, mrd)});
    chk("hz_rs2_pending", {63'd0, hz_rs2_pending}, {63'd0, pend(h2, hs, mrd)});
    @(posedge clk);
    nonempty = (mq.size() != 0);
    exwin = 0; bypass = 0;
    if (ev && m_stall) m_perr = 1;
    if (m_stall && nonempty) begin
      e = mq.pop_front(); m_wb_rd = e.rd; m_wb_data = e.data;
    end else if (ev && erd != 0) begin
      exwin = 1; m_wb_rd = erd; m_wb_data = ed;
    end else if (nonempty) begin
      e = mq.pop_front(); m_wb_rd = e.rd; m_wb_data = e.data;
    end else if (hs) begin
      bypass = 1;
      m_wb_rd = mrd; m_wb_data = (mrd != 0) ? md : '0;
    end else begin
      m_wb_rd = 0; m_wb_data = 0;
    end
    if (hs && !bypass && mrd != 0) mq.push_back('{rd: mrd, data: md});
    if (nonempty && exwin) begin
      if (m_starve == LIMIT - 1) begin m_stall = 1; m_starve = 0; end
      else begin m_starve++; m_stall = 0; end
    end else begin
      m_starve = 0; m_stall = 0;
    end
    last_hs = hs;
    #1;
    chk("WB_rd", {58'd0, WB_rd}, {58'd0, m_wb_rd});
    chk("WB_data", {32'd0, WB_data}, {32'd0, m_wb_data});
    chk("fifo_count", {61'd0, fifo_count}, 64'(mq.size()));
    chk("ex_stall", {63'd0, ex_stall}, {63'd0, m_stall});
    chk("proto_err", {63'd0, proto_err}, {63'd0, m_perr});
    if (WB_rd != 0) wb_log.push_back(WB_rd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 0; mu_valid = 1; mu_rd = 6'd9; mu_data = 32'h55; ex_valid = 0;
    #1;
    chk("rst_mu_ready", {63'd0, mu_ready}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_WB_rd", {58'd0, WB_rd}, 64'd0);
    chk("rst_WB_data", {32'd0, WB_data}, 64'd0);
    chk("rst_fifo_count", {61'd0, fifo_count}, 64'd0);
    chk("rst_ex_stall", {63'd0, ex_stall}, 64'd0);
    chk("rst_proto_err", {63'd0, proto_err}, 64'd0);
    chk("rst_mu_ready_held", {63'd0, mu_ready}, 64'd0);
    model_clear();
    mu_valid = 0;
    rst_n = 1;
    #1;
    chk("post_rst_mu_ready", {63'd0, mu_ready}, 64'd1);
    chk("post_rst_fifo_count", {61'd0, fifo_count}, 64'd0);
  endtask

  initial begin
    int b;
    bit mv;
    logic [REG_W-1:0]  mrd;
    logic [DATA_W-1:0] md;

    #2;
    do_reset();

    // EX only
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    chk("ex_wb_rd", {58'd0, WB_rd}, 64'd5);
    chk("ex_wb_data", {32'd0, WB_data}, 64'hDEADBEEF);
    idle(1);
    chk("ex_idle_rd", {58'd0, WB_rd}, 64'd0);

    // MU bypass, then MU alongside EX
    step(0, 0, 0, 1, 7, 32'h11, 0, 0);
    chk("byp_wb_rd", {58'd0, WB_rd}, 64'd7);
    chk("byp_count", {61'd0, fifo_count}, 64'd0);
    step(1, 3, 32'h33, 1, 7, 32'h11, 0, 0);
    chk("mix_ex_first", {58'd0, WB_rd}, 64'd3);
    idle(1);
    chk("mix_mu_second", {58'd0, WB_rd}, 64'd7);
    idle(2);

    // Full FIFO under continuous EX, then drain in order
    wb_log.delete();
    b = 1;
    for (int k = 0; k < 6; k++) begin
      step(1, 6'(20 + k), 32'(k), 1, 6'(b), 32'(100 + b), 0, 0);
      if (last_hs) b++;
      if (k == 4) begin
        chk("full_count", {61'd0, fifo_count}, 64'd4);
        chk("full_mu_ready", {63'd0, mu_ready}, 64'd0);
      end
    end
    wb_log.delete();
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 0, b <= 5, 6'(b), 32'(100 + b), 0, 0);
      if (last_hs) b++;
    end
    chk("drain_len", 64'(wb_log.size()), 64'd5);
    for (int k = 0; k < 5 && k < wb_log.size(); k++)
      chk("drain_order", {58'd0, wb_log[k]}, 64'(k + 1));

    // Starvation: rd=9 parked behind 8 EX wins, then stall with a protocol violation
    step(1, 3, 32'h3, 1, 9, 32'h99, 0, 0);
    for (int k = 0; k < 8; k++) step(1, 6'(10 + k), 32'(k), 0, 0, 0, 0, 0);
    chk("starve_stall", {63'd0, ex_stall}, 64'd1);
    step(1, 20, 32'hBAD0BAD0, 0, 0, 0, 0, 0);
    chk("stall_wb_rd", {58'd0, WB_rd}, 64'd9);
    chk("stall_proto_err", {63'd0, proto_err}, 64'd1);
    idle(1);
    chk("stall_dropped", {58'd0, WB_rd}, 64'd0);
    chk("perr_sticky", {63'd0, proto_err}, 64'd1);

    // Hazard lookup and zero-destination MU
    step(1, 3, 32'h3, 1, 12, 32'hC, 0, 0);
    ex_valid = 1; ex_rd = 4; mu_valid = 1; mu_rd = 0; hz_rs1 = 12; hz_rs2 = 0;
    #1;
    chk("hz_rs1_12", {63'd0, hz_rs1_pending}, 64'd1);
    chk("hz_rs2_0", {63'd0, hz_rs2_pending}, 64'd0);
    step(1, 4, 32'h4, 1, 0, 32'hFF, 12, 0);
    chk("mu_zero_count", {61'd0, fifo_count}, 64'd1);
    idle(3);

    // Randomized traffic
    mv = 0; mrd = 0; md = 0;
    for (int k = 0; k < 400; k++) begin
      bit ev;
      if (!(mv && !last_hs)) begin
        mv  = ($urandom_range(0, 99) < 50);
        mrd = 6'($urandom_range(0, 15));
        md  = $urandom;
      end
      ev = m_stall ? ($urandom_range(0, 99) < 3) : ($urandom_range(0, 99) < 55);
      step(ev, 6'($urandom_range(0, 15)), $urandom, mv, mrd, md,
           6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)));
    end

    // Reset with buffered results discards them
    step(1, 3, 1, 1, 21, 2, 0, 0);
    step(1, 4, 1, 1, 22, 3, 0, 0);
    do_reset();
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writer end of the 64-entry register file's single write port (WB_data/WB_rd).
- Merges single-cycle EX/ALU results with results from long-latency units (mul/div/load) into one registered write per cycle.
- Long-latency results are buffered in a small FIFO behind a valid/ready handshake.
- Provides pending-destination lookups so ID can stall on RAW/WAW against un-retired results.

Parameters:
DATA_W, 32, result/register data width
REG_W, 6, register index width (64 registers)
FIFO_DEPTH, 4, long-latency result buffer entries (power of 2, >=2)
STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO may lose to EX before EX is stalled

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX result valid this cycle (no ready; must be absorbed)
ex_rd  in  REG_W  EX destination register
ex_data  in  DATA_W  EX result
ex_stall  out  1  registered; upstream must hold ex_valid=0 in this cycle
mu_valid  in  1  long-latency result valid
mu_ready  out  1  FIFO can accept
mu_rd  in  REG_W  long-latency destination
mu_data  in  DATA_W  long-latency result
WB_rd  out  REG_W  register-file write index, registered
WB_data  out  DATA_W  register-file write data, registered
hz_rs1  in  REG_W  ID source 1 lookup
hz_rs2  in  REG_W  ID source 2 lookup
hz_rs1_pending  out  1  hz_rs1 has an un-retired write
hz_rs2_pending  out  1  hz_rs2 has an un-retired write
fifo_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy
proto_err  out  1  sticky: ex_valid seen while ex_stall=1

Behaviour:
- Async reset (rst_n=0): WB_rd=`ZERO_REG, WB_data=0, FIFO empty, fifo_count=0, starve counter=0, ex_stall=0, proto_err=0, mu_ready=0. Reset mid-operation discards all buffered results.
- The register file has no write enable; it writes whenever WB_rd != `ZERO_REG. Every idle cycle must therefore drive WB_rd=`ZERO_REG and WB_data=0.
- mu_ready = rst_n && (fifo_count != FIFO_DEPTH), from registered count.
  - No push when full, even if a pop occurs the same cycle.
  - Handshake completes when mu_valid && mu_ready.
  - mu_rd, mu_data must be held while mu_valid && !mu_ready.
- Destination `ZERO_REG:
  - An EX result is ignored.
  - An accepted MU result is consumed but not pushed; no WB slot is used.
- Per-cycle winner, loaded into WB_rd/WB_data at the next edge (latency 1):
  1. ex_stall=1 and FIFO non-empty: FIFO head wins (pop). If ex_valid=1 here, the EX result is dropped and proto_err sets.
  2. ex_valid=1 with ex_rd != ZERO: EX wins.
  3. FIFO non-empty: head wins (pop).
  4. FIFO empty and MU handshake this cycle: MU bypasses the FIFO (no push, latency 1).
  5. Otherwise: idle values.
- A MU handshake that is not bypassed is pushed at the tail. Push and pop in the same cycle leave fifo_count unchanged.
- Read and write pointers wrap modulo FIFO_DEPTH. Entries retire in strict FIFO order.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and EX wins.
  - Clears when the FIFO pops or is empty.
  - When the counter equals STARVE_LIMIT-1 and increments, ex_stall=1 for exactly the next cycle and the counter clears.
- hz_rsN_pending is combinational. It is 1 iff hz_rsN != ZERO and hz_rsN matches any of:
  - a valid FIFO entry's rd;
  - mu_rd of a handshake this cycle;
  - the current WB_rd.
  Forwarding of the WB value is handled elsewhere.
- Ordering: EX may overtake older MU results. Issue logic must not issue an EX op whose rd is pending; hz_*_pending exists for this check. The block does not reorder-protect.

Test Plan:
- Reset: hold rst_n=0 with mu_valid=1 -> WB_rd=ZERO, WB_data=0, mu_ready=0. After release, mu_ready=1 and fifo_count=0.
- EX only: ex_valid, rd=5, data=0xDEADBEEF -> next cycle WB_rd=5, WB_data=0xDEADBEEF; the following idle cycle WB_rd=ZERO.
- MU bypass and queueing:
  - FIFO empty, MU rd=7 data=0x11 with no EX -> WB_rd=7 next cycle, fifo_count stays 0.
  - Same MU beat alongside EX rd=3 -> WB_rd=3, then WB_rd=7.
- Full/backpressure: 5 MU beats (rd=1..5) during continuous EX traffic -> fifo_count reaches 4, mu_ready=0, beat rd=5 held. On EX release, writes emerge as 1,2,3,4 then 5 with no loss.
- Starvation: FIFO holds rd=9 and ex_valid=1 every cycle -> ex_stall pulses after 8 EX wins. rd=9 retires in the stall cycle. Forcing ex_valid=1 during the stall sets proto_err=1 (sticky) and that EX result never appears on WB.
- Hazard/zero: FIFO holds rd=12, hz_rs1=12, hz_rs2=0 -> hz_rs1_pending=1, hz_rs2_pending=0. MU rd=0 accepted -> no WB write and fifo_count unchanged.
